stereo_frame_writer: RTL

Writer side of the stereo frame store. Accepts a raster-ordered 8-bit grayscale pixel stream from one camera path and writes it into a ping-pong (two-bank) 320×40 pixel BRAM. The existing windowed pixel reader consumes the completed bank. The block owns bank swapping, so the reader never sees a partially written frame, and it flags malformed frames. One instance is used per eye (left/right).

---
 rtl/stereo_pkg.sv | 15 +
 rtl/frame_xy_counter.sv | 51 +++++
 rtl/stereo_frame_writer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/stereo_pkg.sv
// Shared frame-store geometry and writer state encoding for the stereo pixel pipeline.
package stereo_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 40;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = $clog2(IMG_W * IMG_H);

  typedef enum logic [1:0] {
    FW_IDLE  = 2'd0,
    FW_WRITE = 2'd1,
    FW_SWAP  = 2'd2
  } fw_state_t;

endpackage

// File: rtl/frame_xy_counter.sv
// Raster position tracker (h, v, linear addr) with clear, first-pixel load, increment and eol wrap.
// The linear address is kept incrementally so no multiplier is needed.
module frame_xy_counter
  import stereo_pkg::*;
#(
  parameter int W  = IMG_W,
  parameter int H  = IMG_H,
  parameter int HW = $clog2(W),
  parameter int VW = $clog2(H),
  parameter int AW = $clog2(W * H)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_first,
  input  logic          i_inc,
  input  logic          i_wrap,
  output logic [HW-1:0] o_h,
  output logic [VW-1:0] o_v,
  output logic [AW-1:0] o_addr
);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [AW-1:0] r_addr;

  // i_first models "pixel 0 has just been consumed": the next position is h=1, addr=1.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_h    <= '0;
      r_v    <= '0;
      r_addr <= '0;
    end else if (i_first) begin
      r_h    <= HW'(1);
      r_v    <= '0;
      r_addr <= AW'(1);
    end else if (i_wrap) begin
      r_h    <= '0;
      r_v    <= r_v + 1'b1;
      r_addr <= r_addr + 1'b1;
    end else if (i_inc) begin
      r_h    <= r_h + 1'b1;
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_h    = r_h;
  assign o_v    = r_v;
  assign o_addr = r_addr;

endmodule

// File: rtl/stereo_frame_writer.sv
// Ping-pong frame writer: one pixel/cycle in, registered BRAM write one cycle after accept.
// px_ready drops only while a finished frame waits for the reader to release the bank.
module stereo_frame_writer #(
  parameter int   IMG_W  = stereo_pkg::IMG_W,
  parameter int   IMG_H  = stereo_pkg::IMG_H,
  parameter int   PIX_W  = stereo_pkg::PIX_W,
  localparam int  ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk_in,
  input  logic              sys_rst,
  input  logic              px_valid,
  input  logic [PIX_W-1:0]  px_data,
  input  logic              px_sof,
  input  logic              px_eol,
  output logic              px_ready,
  input  logic              rd_lock,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              frame_err
);

  import stereo_pkg::*;

  localparam int HW = $clog2(IMG_W);
  localparam int VW = $clog2(IMG_H);

  fw_state_t         r_state;
  logic              r_wr_bank;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;
  logic              r_frame_done;
  logic              r_frame_err;

  fw_state_t         w_next;
  logic              w_acc;
  logic              w_write;
  logic              w_wr_zero;
  logic              w_err;
  logic              w_first;
  logic              w_inc;
  logic              w_wrap;
  logic              w_clr;
  logic              w_swap;
  logic              w_h_last;
  logic              w_v_last;
  logic [HW-1:0]     w_h;
  logic [VW-1:0]     w_v;
  logic [ADDR_W-1:0] w_addr;

  frame_xy_counter #(
    .W  (IMG_W),
    .H  (IMG_H),
    .HW (HW),
    .VW (VW),
    .AW (ADDR_W)
  ) u_xy (
    .i_clk   (clk_in),
    .i_rst   (sys_rst),
    .i_clr   (w_clr),
    .i_first (w_first),
    .i_inc   (w_inc),
    .i_wrap  (w_wrap),
    .o_h     (w_h),
    .o_v     (w_v),
    .o_addr  (w_addr)
  );

  assign px_ready = ~sys_rst & (r_state != FW_SWAP);
  assign w_acc    = px_valid & px_ready;
  assign w_h_last = (w_h == HW'(IMG_W - 1));
  assign w_v_last = (w_v == VW'(IMG_H - 1));
  assign w_swap   = (r_state == FW_SWAP) & ~rd_lock;

  always_comb begin
    w_next    = r_state;
    w_write   = 1'b0;
    w_wr_zero = 1'b0;
    w_err     = 1'b0;
    w_first   = 1'b0;
    w_inc     = 1'b0;
    w_wrap    = 1'b0;
    w_clr     = 1'b0;
    case (r_state)
      FW_IDLE: begin
        if (w_acc && px_sof) begin
          w_write   = 1'b1;
          w_wr_zero = 1'b1;
          w_first   = 1'b1;
          w_next    = FW_WRITE;
        end
      end
      FW_WRITE: begin
        if (w_acc) begin
          if (px_sof) begin
            // A new sof abandons the partial frame and restarts in place.
            w_err     = 1'b1;
            w_write   = 1'b1;
            w_wr_zero = 1'b1;
            w_first   = 1'b1;
          end else if (px_eol != w_h_last) begin
            w_err  = 1'b1;
            w_clr  = 1'b1;
            w_next = FW_IDLE;
          end else if (px_eol) begin
            w_write = 1'b1;
            if (w_v_last) begin
              w_clr  = 1'b1;
              w_next = FW_SWAP;
            end else begin
              w_wrap = 1'b1;
            end
          end else begin
            w_write = 1'b1;
            w_inc   = 1'b1;
          end
        end
      end
      FW_SWAP: begin
        if (!rd_lock) w_next = FW_IDLE;
      end
      default: w_next = FW_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      r_state      <= FW_IDLE;
      r_wr_bank    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_wr_en      <= w_write;
      r_frame_err  <= w_err;
      r_frame_done <= w_swap;
      if (w_write) begin
        r_wr_addr <= w_wr_zero ? '0 : w_addr;
        r_wr_data <= px_data;
      end
      if (w_swap) r_wr_bank <= ~r_wr_bank;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign wr_bank    = r_wr_bank;
  assign rd_bank    = ~r_wr_bank;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;

endmodule
